// File: rtl/usb2_ep_ctl_pkg.sv
// Shared constants and FSM encoding for the IN-endpoint stream fill controller.
package usb2_ep_ctl_pkg;

  localparam int EP_ADDR_W     = 11;
  localparam int EP_MAX_PKT_HS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_RELEASE = 3'd4
  } ep_state_e;

endpackage

// File: rtl/usb2_ep_flush_timer.sv
// Merges manual flush, SOF-toggle flush and the partial-packet idle timeout
// into one flush_evt; the top decides whether the event closes a packet.
module usb2_ep_flush_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic phy_clk,
  input  logic reset_n,
  input  logic in_fill,
  input  logic pkt_open,
  input  logic hs,
  input  logic flush,
  input  logic sof_flush_en,
  input  logic sof_arrived,
  output logic flush_evt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic          sof_q;
  logic [TW-1:0] tmr;
  logic          counting;
  logic          timeout_hit;
  logic          sof_evt;

  // An idle cycle is one in FILL with bytes pending and no byte accepted.
  assign counting    = in_fill & pkt_open & ~hs;
  assign timeout_hit = (TIMEOUT != 0) && counting && (tmr == T_LAST);
  assign sof_evt     = sof_flush_en & (sof_arrived ^ sof_q);
  assign flush_evt   = flush | sof_evt | timeout_hit;

  // sof_q tracks through reset so a toggle level held across reset is not an edge.
  always_ff @(posedge phy_clk) begin
    sof_q <= sof_arrived;
    if (!reset_n || !counting) begin
      tmr <= '0;
    end else if (tmr != T_LAST) begin
      tmr <= tmr + 1'b1;
    end
  end

endmodule

// File: rtl/usb2_ep_stream_ctl.sv
// Fills one IN endpoint buffer from a byte stream and runs the commit/ack
// handshake that makes the endpoint swap buffers.
module usb2_ep_stream_ctl
  import usb2_ep_ctl_pkg::*;
#(
  parameter int MAX_PKT = EP_MAX_PKT_HS,
  parameter int TIMEOUT = 4096
) (
  input  logic                 phy_clk,
  input  logic                 reset_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 flush,
  input  logic                 sof_flush_en,
  input  logic                 sof_arrived,
  output logic [EP_ADDR_W-1:0] buf_in_addr,
  output logic [7:0]           buf_in_data,
  output logic                 buf_in_wren,
  input  logic                 buf_in_ready,
  output logic                 buf_in_commit,
  output logic [EP_ADDR_W-1:0] buf_in_commit_len,
  input  logic                 buf_in_commit_ack,
  output logic [15:0]          pkt_count,
  output ep_state_e            state_dbg
);

  localparam logic [EP_ADDR_W-1:0] CNT_LAST = EP_ADDR_W'(MAX_PKT - 1);

  ep_state_e            state;
  logic [EP_ADDR_W-1:0] cnt;
  logic                 hs;
  logic                 pkt_open;
  logic                 last_byte;
  logic                 flush_evt;
  logic                 close_pkt;

  // Stream handshake: a byte transfers on every rising edge where s_valid and
  // s_ready are both 1; s_valid must not depend on s_ready.
  assign s_ready   = (state == ST_FILL) & buf_in_ready;
  assign hs        = s_valid & s_ready;
  assign pkt_open  = (cnt != '0);
  assign last_byte = hs & (cnt == CNT_LAST);
  assign close_pkt = last_byte | (flush_evt & (pkt_open | hs));
  assign state_dbg = state;

  usb2_ep_flush_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_flush_timer (
    .phy_clk      (phy_clk),
    .reset_n      (reset_n),
    .in_fill      (state == ST_FILL),
    .pkt_open     (pkt_open),
    .hs           (hs),
    .flush        (flush),
    .sof_flush_en (sof_flush_en),
    .sof_arrived  (sof_arrived),
    .flush_evt    (flush_evt)
  );

  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      buf_in_addr       <= '0;
      buf_in_data       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
      pkt_count         <= '0;
    end else begin
      buf_in_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (buf_in_ready) begin
            state <= ST_FILL;
            cnt   <= '0;
          end
        end
        ST_FILL: begin
          if (hs) begin
            buf_in_addr <= cnt;
            buf_in_data <= s_data;
            buf_in_wren <= 1'b1;
            cnt         <= cnt + 1'b1;
          end
          // A byte accepted in the closing cycle belongs to this packet.
          if (close_pkt) begin
            state             <= ST_SETTLE;
            buf_in_commit_len <= cnt + {{(EP_ADDR_W-1){1'b0}}, hs};
          end
        end
        ST_SETTLE: begin
          state         <= ST_COMMIT;
          buf_in_commit <= 1'b1;
        end
        ST_COMMIT: begin
          if (buf_in_commit_ack) begin
            state         <= ST_RELEASE;
            buf_in_commit <= 1'b0;
            pkt_count     <= pkt_count + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!buf_in_commit_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ep_stream_ctl.sv
// Scenario bench for usb2_ep_stream_ctl: directed scenarios plus a randomized
// run, all scored against a packet-level model of the byte stream.
module tb_usb2_ep_stream_ctl;
  import usb2_ep_ctl_pkg::*;

  localparam int MAX_PKT = 1024;
  localparam int TIMEOUT = 16;

  logic        phy_clk;
  logic        reset_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        flush;
  logic        sof_flush_en;
  logic        sof_arrived;
  logic [10:0] buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_ready;
  logic        buf_in_commit;
  logic [10:0] buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [15:0] pkt_count;
  ep_state_e   state_dbg;

  usb2_ep_stream_ctl #(
    .MAX_PKT (MAX_PKT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .phy_clk           (phy_clk),
    .reset_n           (reset_n),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .flush             (flush),
    .sof_flush_en      (sof_flush_en),
    .sof_arrived       (sof_arrived),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .pkt_count         (pkt_count),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    phy_clk = 1'b0;
    forever #5 phy_clk = ~phy_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mdl_cnt = 0;      // bytes in the packet being built
  int mdl_pkts = 0;     // packets the endpoint has acknowledged
  int idle_cnt = 0;     // consecutive byte-less cycles with a partial packet
  int close_cyc = 0;
  int phase = 0;        // 0 open, 1 closed awaiting commit, 2 committed awaiting ack low
  int n_commits = 0;
  int last_len = 0;
  int last_hs_cyc = 0;
  int rise_cyc = 0;
  logic [18:0] exp_q[$];
  logic [10:0] len_q[$];
  logic        sof_prev;
  logic        c_prev;
  logic [18:0] e_wr;
  logic [10:0] e_len;
  logic        m_hs;
  logic        m_fl;

  int   ack_dly = 4;
  int   ack_wait = 0;
  logic ack_en = 1'b1;

  // Monitor samples mid-cycle; inputs only change just after rising edges.
  always @(negedge phy_clk) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      len_q.delete();
      mdl_cnt  = 0;
      mdl_pkts = 0;
      idle_cnt = 0;
      phase    = 0;
      c_prev   = 1'b0;
      sof_prev = sof_arrived;
    end else begin
      if (buf_in_wren) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got addr=%0d data=%0h want no write", buf_in_addr, buf_in_data);
        end else begin
          e_wr = exp_q.pop_front();
          if ({buf_in_addr, buf_in_data} !== e_wr) begin
            n_err++;
            $display("FAIL wr_data: got addr=%0d data=%0h want addr=%0d data=%0h",
                     buf_in_addr, buf_in_data, e_wr[18:8], e_wr[7:0]);
          end
        end
      end
      if (buf_in_commit && !c_prev) begin
        rise_cyc = cyc;
        last_len = int'(buf_in_commit_len);
        n_vec++;
        if (len_q.size() == 0) begin
          n_err++;
          $display("FAIL commit_unexpected: got len=%0d want no commit", buf_in_commit_len);
        end else begin
          e_len = len_q.pop_front();
          if (buf_in_commit_len !== e_len) begin
            n_err++;
            $display("FAIL commit_len: got %0d want %0d", buf_in_commit_len, e_len);
          end
        end
        // Closing decision at cycle c -> SETTLE at c+1 -> commit visible at c+2.
        n_vec++;
        if (cyc != close_cyc + 2) begin
          n_err++;
          $display("FAIL commit_latency: got %0d cycles want 2", cyc - close_cyc);
        end
      end
      if (!buf_in_commit && c_prev) begin
        mdl_pkts++;
        n_commits++;
        phase = 2;
        n_vec++;
        if (pkt_count !== 16'(mdl_pkts)) begin
          n_err++;
          $display("FAIL pkt_count: got %0d want %0d", pkt_count, 16'(mdl_pkts));
        end
      end
      if ((phase != 0 || !buf_in_ready) && s_ready) begin
        n_vec++;
        n_err++;
        $display("FAIL s_ready_closed: got 1 want 0 (phase %0d ready %0b)", phase, buf_in_ready);
      end
      if (phase == 2 && !buf_in_commit_ack) phase = 0;

      // Reference model: packet boundaries from byte count and flush rules.
      m_hs = s_valid && s_ready;
      if (m_hs) begin
        exp_q.push_back({11'(mdl_cnt), s_data});
        mdl_cnt++;
        idle_cnt = 0;
        last_hs_cyc = cyc;
      end else if (mdl_cnt > 0) begin
        idle_cnt++;
      end
      m_fl = flush || (sof_flush_en && (sof_arrived != sof_prev)) || (idle_cnt == TIMEOUT);
      if (mdl_cnt > 0 && (mdl_cnt == MAX_PKT || m_fl)) begin
        len_q.push_back(11'(mdl_cnt));
        close_cyc = cyc;
        mdl_cnt   = 0;
        idle_cnt  = 0;
        phase     = 1;
      end
      sof_prev = sof_arrived;
      c_prev   = buf_in_commit;
    end
  end

  // Endpoint model: acks a commit after ack_dly cycles, drops ack after commit falls.
  initial begin
    buf_in_commit_ack = 1'b0;
    forever begin
      @(posedge phy_clk); #1;
      if (!reset_n) begin
        buf_in_commit_ack = 1'b0;
        ack_wait = 0;
      end else if (!buf_in_commit_ack) begin
        if (buf_in_commit && ack_en) begin
          ack_wait++;
          if (ack_wait >= ack_dly) begin
            buf_in_commit_ack = 1'b1;
            ack_wait = 0;
          end
        end else begin
          ack_wait = 0;
        end
      end else if (!buf_in_commit) begin
        buf_in_commit_ack = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d);
    logic took;
    took = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int g = 0; g < 4000 && !took; g++) begin
      @(negedge phy_clk);
      took = s_ready;
      @(posedge phy_clk); #1;
    end
    s_valid = 1'b0;
    if (!took) begin
      n_vec++;
      n_err++;
      $display("FAIL send_byte: got no handshake want handshake within bound");
    end
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge phy_clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge phy_clk); #1;
    end
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < 5000 && !ok; g++) begin
      @(posedge phy_clk); #1;
      ok = (n_commits >= target) && (phase == 0);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_done: got %0d commits want %0d within bound", n_commits, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle_cycles(3);
    @(negedge phy_clk);
    n_vec++;
    if ({s_ready, buf_in_wren, buf_in_commit} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctl: got ready/wren/commit=%b want 000", {s_ready, buf_in_wren, buf_in_commit});
    end
    n_vec++;
    if ({buf_in_addr, buf_in_data, buf_in_commit_len} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%0d data=%0d len=%0d want 0", buf_in_addr, buf_in_data, buf_in_commit_len);
    end
    n_vec++;
    if (pkt_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_pkt_count: got %0d want 0", pkt_count);
    end
    n_vec++;
    if (state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE);
    end
    @(posedge phy_clk); #1;
    reset_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_full_packet();
    int start;
    start = n_commits;
    ack_dly = 4;
    send_n(MAX_PKT);
    wait_done(start + 1);
    n_vec++;
    if (last_len != MAX_PKT) begin
      n_err++;
      $display("FAIL full_len: got %0d want %0d", last_len, MAX_PKT);
    end
    n_vec++;
    if (pkt_count !== 16'd1) begin
      n_err++;
      $display("FAIL full_pkt_count: got %0d want 1", pkt_count);
    end
  endtask

  task automatic test_manual_flush();
    int start;
    start = n_commits;
    send_n(10);
    pulse_flush();
    wait_done(start + 1);
    n_vec++;
    if (last_len != 10) begin
      n_err++;
      $display("FAIL flush_len: got %0d want 10", last_len);
    end
    pulse_flush();
    idle_cycles(20);
    n_vec++;
    if (n_commits != start + 1 || buf_in_commit) begin
      n_err++;
      $display("FAIL empty_flush: got %0d commits want %0d", n_commits, start + 1);
    end
  endtask

  task automatic test_timeout();
    int start;
    start = n_commits;
    send_n(3);
    wait_done(start + 1);
    n_vec++;
    if (last_len != 3) begin
      n_err++;
      $display("FAIL timeout_len: got %0d want 3", last_len);
    end
    // 16 idle cycles after the last byte, then SETTLE, then commit.
    n_vec++;
    if (rise_cyc - last_hs_cyc != TIMEOUT + 2) begin
      n_err++;
      $display("FAIL timeout_delay: got %0d want %0d", rise_cyc - last_hs_cyc, TIMEOUT + 2);
    end
  endtask

  task automatic test_endpoint_full();
    int start;
    start = n_commits;
    send_n(4);
    pulse_flush();
    wait_done(start + 1);
    send_n(6);
    pulse_flush();
    wait_done(start + 2);
    buf_in_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5a;
    for (int i = 0; i < 30; i++) begin
      @(negedge phy_clk);
      n_vec++;
      if (s_ready || buf_in_wren) begin
        n_err++;
        $display("FAIL ep_full_stall: got ready=%b wren=%b want 0 0", s_ready, buf_in_wren);
      end
      @(posedge phy_clk); #1;
    end
    s_valid = 1'b0;
    buf_in_ready = 1'b1;
    send_byte(8'($urandom));
    @(negedge phy_clk);
    n_vec++;
    if (!buf_in_wren || buf_in_addr !== 11'd0) begin
      n_err++;
      $display("FAIL ep_full_resume: got wren=%b addr=%0d want 1 0", buf_in_wren, buf_in_addr);
    end
    @(posedge phy_clk); #1;
    send_n(1);
    pulse_flush();
    wait_done(start + 3);
    n_vec++;
    if (last_len != 2) begin
      n_err++;
      $display("FAIL ep_full_len: got %0d want 2", last_len);
    end
  endtask

  task automatic test_sof_same_cycle();
    int start;
    start = n_commits;
    sof_flush_en = 1'b1;
    send_n(4);
    s_data  = 8'($urandom);
    s_valid = 1'b1;
    sof_arrived = ~sof_arrived;
    @(negedge phy_clk);
    n_vec++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sof_hs_ready: got %b want 1", s_ready);
    end
    @(posedge phy_clk); #1;
    s_valid = 1'b0;
    wait_done(start + 1);
    n_vec++;
    if (last_len != 5) begin
      n_err++;
      $display("FAIL sof_len: got %0d want 5", last_len);
    end
    sof_flush_en = 1'b0;
    send_n(3);
    sof_arrived = ~sof_arrived;
    idle_cycles(5);
    n_vec++;
    if (n_commits != start + 1 || buf_in_commit) begin
      n_err++;
      $display("FAIL sof_disabled: got %0d commits want %0d", n_commits, start + 1);
    end
    pulse_flush();
    wait_done(start + 2);
    n_vec++;
    if (last_len != 3) begin
      n_err++;
      $display("FAIL sof_disabled_len: got %0d want 3", last_len);
    end
  endtask

  task automatic test_reset_mid_commit();
    int  start;
    bit  seen;
    ack_en = 1'b0;
    send_n(7);
    pulse_flush();
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(posedge phy_clk); #1;
      seen = buf_in_commit;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL rmc_commit: got commit=0 want 1 before reset");
    end
    idle_cycles(2);
    reset_n = 1'b0;
    @(posedge phy_clk); #1;
    reset_n = 1'b1;
    ack_en  = 1'b1;
    @(negedge phy_clk);
    n_vec++;
    if ({buf_in_commit, buf_in_wren} !== 2'b00 || pkt_count !== 16'd0 || state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL rmc_after_reset: got commit=%b wren=%b pkt=%0d state=%0d want 0 0 0 %0d",
               buf_in_commit, buf_in_wren, pkt_count, state_dbg, ST_IDLE);
    end
    @(posedge phy_clk); #1;
    start = n_commits;
    send_byte(8'($urandom));
    @(negedge phy_clk);
    n_vec++;
    if (!buf_in_wren || buf_in_addr !== 11'd0) begin
      n_err++;
      $display("FAIL rmc_restart_addr: got wren=%b addr=%0d want 1 0", buf_in_wren, buf_in_addr);
    end
    @(posedge phy_clk); #1;
    pulse_flush();
    wait_done(start + 1);
    n_vec++;
    if (last_len != 1 || pkt_count !== 16'd1) begin
      n_err++;
      $display("FAIL rmc_next_pkt: got len=%0d pkt=%0d want 1 1", last_len, pkt_count);
    end
  endtask

  task automatic test_random();
    int quiet;
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet == 0 && $urandom_range(0, 150) == 0) quiet = 20;
      if (quiet > 0) begin
        s_valid = 1'b0;
        quiet--;
      end else begin
        s_valid = ($urandom_range(0, 3) != 0);
      end
      s_data       = 8'($urandom);
      flush        = ($urandom_range(0, 40) == 0);
      buf_in_ready = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 30) == 0) sof_arrived = ~sof_arrived;
      if ($urandom_range(0, 50) == 0) sof_flush_en = ~sof_flush_en;
      ack_dly = $urandom_range(3, 6);
      @(posedge phy_clk); #1;
    end
    s_valid = 1'b0;
    flush = 1'b0;
    buf_in_ready = 1'b1;
    idle_cycles(40);
    wait_done(n_commits);
    n_vec++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d writes %0d commits pending want 0 0", exp_q.size(), len_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n      = 1'b0;
    s_data       = 8'd0;
    s_valid      = 1'b0;
    flush        = 1'b0;
    sof_flush_en = 1'b0;
    sof_arrived  = 1'b0;
    buf_in_ready = 1'b1;
    @(posedge phy_clk); #1;
    test_reset();
    test_full_packet();
    test_manual_flush();
    test_timeout();
    test_endpoint_full();
    test_sof_same_cycle();
    test_reset_mid_commit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb2_ep_stream_ctl.md
# usb2_ep_stream_ctl

Fill controller for one IN endpoint's double-buffered packet RAM. It accepts a byte stream (valid/ready) and writes it into the endpoint buffer at incrementing addresses. It closes each packet at `MAX_PKT` bytes or on a flush event, and runs the commit/ack handshake so the endpoint swaps buffers. It sits between a data source (e.g. TS capture) and the endpoint's `buf_in_*` port, in the `phy_clk` domain.

## Interface
- `MAX_PKT`, 1024: bytes per full packet; 1..1024.
- `TIMEOUT`, 4096: idle cycles in FILL with a partial packet before auto-flush; 0 disables the timeout.
- `phy_clk` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: a byte is accepted on cycles where `s_valid & s_ready`.
- `flush` in 1: level-sampled pulse; close the current partial packet.
- `sof_flush_en` in 1: when 1, every SOF toggle acts as a flush.
- `sof_arrived` in 1: SOF toggle; every edge marks one microframe.
- `buf_in_addr` out 11: endpoint write address, relative to the current buffer.
- `buf_in_data` out 8: write data.
- `buf_in_wren` out 1: write strobe.
- `buf_in_ready` in 1: the endpoint's current buffer is free.
- `buf_in_commit` out 1: commit request.
- `buf_in_commit_len` out 11: byte count of the committed packet.
- `buf_in_commit_ack` in 1: commit acknowledge from the endpoint.
- `pkt_count` out 16: committed packets; wraps modulo 2^16.

## Operation
- **States:**
  - IDLE: wait for `buf_in_ready`=1, then go to FILL.
  - FILL: accept bytes.
  - SETTLE: one cycle so the last write lands before the commit.
  - COMMIT: hold `buf_in_commit`=1 until `buf_in_commit_ack`=1.
  - RELEASE: commit=0; wait for ack=0, then go to IDLE.
- **Stream acceptance:** `s_ready` = (state==FILL) & `buf_in_ready`, combinational.
- **Byte counter:** `cnt` is 11 bits, cleared on entry to FILL. Each accepted byte:
  - registers `buf_in_addr`=`cnt`, `buf_in_data`=`s_data`, `buf_in_wren`=1;
  - then increments `cnt`.
- **Full packet:** a handshake with `cnt`==`MAX_PKT`-1 moves FILL to SETTLE, with `buf_in_commit_len`=`MAX_PKT`.
- **Flush sources:**
  - `flush`=1;
  - a `sof_arrived` edge (vs. a registered copy) while `sof_flush_en`=1;
  - the timeout expiring.
- **Flush action:** a flush event in FILL with `cnt`>0 (counting a same-cycle handshake) moves to SETTLE with `buf_in_commit_len`=resulting count.
- **Flushes that are ignored (not queued):** any flush with `cnt`==0, and any flush outside FILL.
- **Timeout:** counts cycles in FILL with `cnt`>0 and no handshake. It clears on a handshake or when leaving FILL. Reaching `TIMEOUT`-1 is a flush event.
- **Simultaneous events:** full packet plus flush in the same cycle gives one commit of `MAX_PKT`. Handshake plus flush gives one commit that includes the byte.
- **Commit completion:** `pkt_count` increments on the COMMIT to RELEASE transition.
- **Buffer swap:** after RELEASE the endpoint has swapped buffers. IDLE re-checks `buf_in_ready` for the new buffer, so the source stalls while both buffers are full.
- **Reset** (`reset_n`=0 at a clock edge), including mid-packet or mid-commit:
  - state goes to IDLE;
  - `cnt`, the timeout counter and `pkt_count` clear to 0;
  - all outputs go to 0, including `buf_in_commit`, `buf_in_wren`, `buf_in_addr`, `buf_in_data`, `buf_in_commit_len` and `s_ready`;
  - any partial packet is discarded.

## Timing
- **Write latency:** handshake at edge N gives `buf_in_wren`=1 during cycle N+1. Writes run back-to-back at one byte per cycle.
- **Commit latency:** the last handshake at N puts SETTLE in N+1, with that cycle's `wren` being the final write. `buf_in_commit` is 1 from N+2 (registered).
- **Commit length:** `buf_in_commit_len` is stable from SETTLE until RELEASE exits.
- **Commit hold:** commit stays 1 for at least one cycle and until ack is sampled 1; it drops the cycle after. Ack latency from the endpoint is ≥3 cycles (synchronizer).
- **No timeouts on the handshake:** the controller never de-asserts commit before ack and never re-asserts it before ack falls.
- **Minimum packet turnaround:** last byte to next accepted byte ≥ 6 cycles plus the endpoint ack time.

## Structure
- **Package `usb2_ep_ctl_pkg`:**
  - state encoding constants (IDLE, FILL, SETTLE, COMMIT, RELEASE);
  - `EP_ADDR_W`=11;
  - `EP_MAX_PKT_HS`=1024.
- **Sub-module `usb2_ep_flush_timer`:** SOF edge detect, `sof_flush_en` gating, the timeout counter and the OR of flush sources. It outputs a single `flush_evt`.
- **Top level:** the FSM, byte counter, write registers and `pkt_count`.

## Test plan
- **Full packet:** `MAX_PKT`=1024, 1024 bytes streamed back-to-back with ack after 4 cycles.
  - Expect 1024 `wren` at addr 0..1023, then commit with len=1024.
  - Expect `pkt_count`=1 and `s_ready`=0 from SETTLE through RELEASE.
- **Manual flush:** 10 bytes then `flush` pulse.
  - Expect commit with len=10.
  - A second flush with `cnt`=0 produces no commit.
- **Timeout:** `TIMEOUT`=16, 3 bytes then an idle source.
  - Expect commit len=3 exactly 16 idle cycles after the last handshake.
- **Endpoint full:** `buf_in_ready` held 0 after two commits.
  - Expect `s_ready` stays 0 and no `wren`.
  - After ready rises, FILL resumes at addr 0.
- **Same-cycle flush and handshake:** SOF edge with `sof_flush_en`=1 in the same cycle as handshake of byte 5 → one commit, len=5.
  - With `sof_flush_en`=0, the SOF edge is ignored.
- **Reset mid-commit:** `reset_n`=0 for 1 cycle while commit is high.
  - Expect commit, `wren` and `pkt_count` all 0 the next cycle, state IDLE.
  - The next packet starts at addr 0.
